alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu.sv | 150 +++++++++++++++
 tb/tb_alu.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Single-cycle RV32I integer ALU: decodes R-type and I-type arithmetic/logic
// instructions and registers the result together with an illegal-instruction flag.
module alu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   input  logic [31:0] I,
   output logic [31:0] o,
   output logic        illegal
);

   localparam logic [6:0] OPC_R   = 7'b0110011;
   localparam logic [6:0] OPC_I   = 7'b0010011;
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   logic [6:0]  opcode_s;
   logic [2:0]  funct3_s;
   logic [6:0]  funct7_s;
   logic [31:0] imm_s;
   logic [31:0] op2_s;
   logic [4:0]  shamt_s;
   logic [31:0] add_s;
   logic [31:0] sub_s;
   logic [31:0] sll_s;
   logic [31:0] srl_s;
   logic [31:0] sra_s;
   logic [31:0] slt_s;
   logic [31:0] sltu_s;
   logic [31:0] res_s;
   logic        ill_s;
   logic        unused_s;

   assign opcode_s = I[6:0];
   assign funct3_s = I[14:12];
   assign funct7_s = I[31:25];
   assign imm_s    = {{20{I[31]}}, I[31:20]};

   // Register-index fields carry no meaning for this block.
   assign unused_s = ^{I[19:15], I[11:7]};

   // Operand select and the shared arithmetic datapath.
   always_comb begin
      if (opcode_s == OPC_R) begin
         op2_s = rs2;
      end else begin
         op2_s = imm_s;
      end
      shamt_s = op2_s[4:0];
      add_s   = rs1 + op2_s;
      sub_s   = rs1 - op2_s;
      sll_s   = rs1 << shamt_s;
      srl_s   = rs1 >> shamt_s;
      sra_s   = $signed(rs1) >>> shamt_s;
      slt_s   = {31'd0, ($signed(rs1) < $signed(op2_s))};
      sltu_s  = {31'd0, (rs1 < op2_s)};
   end

   // Instruction decode: pick the result or flag an unsupported encoding.
   always_comb begin
      res_s = 32'd0;
      ill_s = 1'b1;
      if (opcode_s == OPC_R) begin
         if (funct7_s == F7_BASE) begin
            ill_s = 1'b0;
            case (funct3_s)
               3'b000:  res_s = add_s;
               3'b001:  res_s = sll_s;
               3'b010:  res_s = slt_s;
               3'b011:  res_s = sltu_s;
               3'b100:  res_s = rs1 ^ op2_s;
               3'b101:  res_s = srl_s;
               3'b110:  res_s = rs1 | op2_s;
               3'b111:  res_s = rs1 & op2_s;
               default: begin
                  res_s = 32'd0;
                  ill_s = 1'b1;
               end
            endcase
         end else if (funct7_s == F7_ALT) begin
            case (funct3_s)
               3'b000: begin
                  res_s = sub_s;
                  ill_s = 1'b0;
               end
               3'b101: begin
                  res_s = sra_s;
                  ill_s = 1'b0;
               end
               default: begin
                  res_s = 32'd0;
                  ill_s = 1'b1;
               end
            endcase
         end else begin
            res_s = 32'd0;
            ill_s = 1'b1;
         end
      end else if (opcode_s == OPC_I) begin
         ill_s = 1'b0;
         case (funct3_s)
            3'b000: res_s = add_s;
            3'b010: res_s = slt_s;
            3'b011: res_s = sltu_s;
            3'b100: res_s = rs1 ^ op2_s;
            3'b110: res_s = rs1 | op2_s;
            3'b111: res_s = rs1 & op2_s;
            3'b001: begin
               if (funct7_s == F7_BASE) begin
                  res_s = sll_s;
               end else begin
                  res_s = 32'd0;
                  ill_s = 1'b1;
               end
            end
            3'b101: begin
               // Upper immediate bits double as the logical/arithmetic selector.
               if (funct7_s == F7_BASE) begin
                  res_s = srl_s;
               end else if (funct7_s == F7_ALT) begin
                  res_s = sra_s;
               end else begin
                  res_s = 32'd0;
                  ill_s = 1'b1;
               end
            end
            default: begin
               res_s = 32'd0;
               ill_s = 1'b1;
            end
         endcase
      end else begin
         res_s = 32'd0;
         ill_s = 1'b1;
      end
   end

   // Output registers; reset clears them without waiting for a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o       <= 32'd0;
         illegal <= 1'b0;
      end else begin
         o       <= res_s;
         illegal <= ill_s;
      end
   end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors with known answers, reset
// behaviour, and randomized instructions against an arithmetic reference model.
module tb_alu;

   logic        clk;
   logic        rst_n;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic [31:0] I;
   logic [31:0] o;
   logic        illegal;

   int tests;
   int fails;

   alu dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .rs1     (rs1),
      .rs2     (rs2),
      .I       (I),
      .o       (o),
      .illegal (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: instruction semantics computed from field values directly.
   function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] ins,
                                     output logic [31:0] r, output logic ill);
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] y;
      logic [63:0] ext;
      int unsigned sh;
      bit          is_r;
      bit          ok;
      opc  = ins[6:0];
      f3   = ins[14:12];
      f7   = ins[31:25];
      is_r = (opc == 7'h33);
      ok   = 1'b0;
      r    = 32'd0;
      if (is_r) begin
         y  = b;
         ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      end else begin
         y = {{20{ins[31]}}, ins[31:20]};
         if (opc == 7'h13) begin
            if (f3 == 3'd1)      ok = (f7 == 7'h00);
            else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
            else                 ok = 1'b1;
         end
      end
      sh = y % 32;
      if (ok) begin
         case (f3)
            3'd0: r = (is_r && f7 == 7'h20) ? a - y : a + y;
            3'd1: r = a << sh;
            3'd2: r = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3: r = (a < y) ? 32'd1 : 32'd0;
            3'd4: r = a ^ y;
            3'd5: begin
               if (f7 == 7'h20) begin
                  ext = {{32{a[31]}}, a};
                  ext = ext >> sh;
                  r   = ext[31:0];
               end else begin
                  r = a >> sh;
               end
            end
            3'd6: r = a | y;
            default: r = a & y;
         endcase
      end
      ill = !ok;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one instruction, check the registered result, then disturb inputs mid-cycle.
   task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ins, input logic [31:0] exp_o,
                        input logic exp_ill);
      @(negedge clk);
      rs1 = a;
      rs2 = b;
      I   = ins;
      @(posedge clk);
      #1;
      check({tag, ".o"}, o, exp_o);
      check({tag, ".illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
      rs1 = $urandom;
      rs2 = $urandom;
      I   = $urandom;
      #2;
      check({tag, ".hold"}, o, exp_o);
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [31:0] ri;
      logic [31:0] eo;
      logic        ei;
      logic [6:0]  opc;
      logic [6:0]  f7;
      int          sel;
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      rs1   = 32'd10000;
      rs2   = 32'd23456;
      I     = 32'h003100b3;
      #1;
      check("reset.o", o, 32'd0);
      check("reset.illegal", {31'd0, illegal}, 32'd0);
      @(posedge clk);
      #1;
      check("reset_edge.o", o, 32'd0);
      // First result after release comes from the first edge with rst_n high.
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("first_after_reset.o", o, 32'd33456);

      apply("add",  32'd10000, 32'd23456, 32'h003100b3, 32'h000082B0, 1'b0);
      apply("sll0", 32'd10000, 32'd23456, 32'h003110b3, 32'd10000,    1'b0);
      apply("or",   32'd10000, 32'd23456, 32'h003160b3, 32'h00007FB0, 1'b0);
      apply("sub",  32'd10000, 32'd23456, 32'h403100b3, 32'hFFFFCB70, 1'b0);
      apply("and",  32'd10000, 32'd23456, 32'h003170b3, 32'h00000300, 1'b0);
      apply("sra",  32'h80000000, 32'd4, 32'h403150b3, 32'hF8000000, 1'b0);
      apply("srl",  32'h80000000, 32'd4, 32'h003150b3, 32'h08000000, 1'b0);
      apply("slt",  32'h80000000, 32'd4, 32'h003120b3, 32'd1,        1'b0);
      apply("sltu", 32'h80000000, 32'd4, 32'h003130b3, 32'd0,        1'b0);
      apply("addi_m1",  32'd0, 32'd23456, 32'hfff10093, 32'hFFFFFFFF, 1'b0);
      apply("sltiu_m1", 32'd5, 32'd23456, 32'hfff13093, 32'd1,        1'b0);
      apply("srai",  32'h80000010, 32'd0, 32'h40415093, 32'hF8000001, 1'b0);
      apply("slli_bad", 32'd1, 32'd0, 32'h40411093, 32'd0, 1'b1);
      apply("ecall",    32'd10000, 32'd23456, 32'h00000073, 32'd0, 1'b1);
      apply("r_f7_01",  32'd10000, 32'd23456, 32'h023100b3, 32'd0, 1'b1);
      apply("r_alt_or", 32'd10000, 32'd23456, 32'h403160b3, 32'd0, 1'b1);

      // Mid-cycle reset discards the in-flight ADD and clears the flag.
      apply("pre_reset", 32'd10000, 32'd23456, 32'h003100b3, 32'd33456, 1'b0);
      rst_n = 1'b0;
      #1;
      check("async_reset.o", o, 32'd0);
      check("async_reset.illegal", {31'd0, illegal}, 32'd0);
      rs1 = 32'd10000;
      rs2 = 32'd23456;
      I   = 32'h00000073;
      @(posedge clk);
      #1;
      check("reset_hold.o", o, 32'd0);
      check("reset_hold.illegal", {31'd0, illegal}, 32'd0);
      @(negedge clk);
      I     = 32'h403100b3;
      rst_n = 1'b1;
      #1;
      check("release_wait.o", o, 32'd0);
      @(posedge clk);
      #1;
      check("release_first.o", o, 32'hFFFFCB70);
      check("release_first.illegal", {31'd0, illegal}, 32'd0);

      for (int n = 0; n < 300; n++) begin
         sel = $urandom_range(0, 9);
         if (sel < 4)      opc = 7'h33;
         else if (sel < 8) opc = 7'h13;
         else              opc = 7'($urandom);
         sel = $urandom_range(0, 3);
         if (sel == 0)      f7 = 7'h00;
         else if (sel == 1) f7 = 7'h20;
         else if (sel == 2) f7 = 7'($urandom);
         else               f7 = 7'h00;
         ri = $urandom;
         ri[6:0]   = opc;
         ri[31:25] = f7;
         ra = $urandom;
         rb = $urandom;
         if (n % 5 == 0) ra = 32'h80000000;
         ref_model(ra, rb, ri, eo, ei);
         apply("random", ra, rb, ri, eo, ei);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
